// File: rtl/axis_read_ctrl.sv
`timescale 1ns/1ps
// AXI read-address sequencer for one stream: hands the word count to axis_read_data, then issues
// AR bursts capped by BURST_MAX and outstanding-beat credit. Define AXIS_READ_CTRL_4K_EN to split at 4 KB.
module axis_read_ctrl #(
   parameter int ADDR_WIDTH      = 32,
   parameter int CFG_DWIDTH      = 32,
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int DATA_WIDTH      = 32,
   parameter int WIDTH_RATIO     = 2,
   parameter int BURST_MAX       = 16,
   parameter int OUTSTANDING_MAX = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cfg_address,
   input  logic [CFG_DWIDTH-1:0] cfg_length,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic [CFG_DWIDTH-1:0] data_cfg_length,
   output logic                  data_cfg_valid,
   input  logic                  data_cfg_ready,
   output logic [ADDR_WIDTH-1:0] axi_araddr,
   output logic [7:0]            axi_arlen,
   output logic                  axi_arvalid,
   input  logic                  axi_arready,
   input  logic                  axi_rbeat,
   output logic                  done
);
   localparam int CW          = CFG_DWIDTH;
   localparam int BYTE_SHIFT  = $clog2(AXI_DATA_WIDTH / 8);
   localparam int RATIO_SHIFT = $clog2(AXI_DATA_WIDTH / DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      CONFIG = 3'b010,
      ADDR   = 3'b100
   } state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr, addr_n, araddr_n;
   logic [CW-1:0]         beats_rem, beats_rem_n, rem_after;
   logic [CW-1:0]         outstanding, outstanding_n, out_inc;
   logic [CW-1:0]         data_len_n, cur_burst, nb;
   logic [CW:0]           len_round;
   logic [7:0]            arlen_n;
   logic                  arvalid_n, done_n, hs;

   function automatic logic [CW-1:0] burst_cap(input logic [CW-1:0] rem);
      if (rem > CW'(BURST_MAX)) return CW'(BURST_MAX);
      else return rem;
   endfunction

`ifdef AXIS_READ_CTRL_4K_EN
   function automatic logic [CW-1:0] clamp_4k(input logic [CW-1:0] b, input logic [11:0] off);
      logic [12:0] to_4k;
      to_4k = (13'd4096 - {1'b0, off}) >> BYTE_SHIFT;
      if (CW'(to_4k) < b) return CW'(to_4k);
      else return b;
   endfunction
`endif

   function automatic logic fits(input logic [CW-1:0] o, input logic [CW-1:0] b);
      return ({1'b0, o} + {1'b0, b}) <= (CW+1)'(OUTSTANDING_MAX);
   endfunction

   assign cfg_ready      = (state == IDLE);
   assign data_cfg_valid = (state == CONFIG);

   // Next-state, burst planning and credit accounting.
   always_comb begin
      state_n     = state;
      addr_n      = addr;
      beats_rem_n = beats_rem;
      data_len_n  = data_cfg_length;
      araddr_n    = axi_araddr;
      arlen_n     = axi_arlen;
      arvalid_n   = axi_arvalid;
      done_n      = 1'b0;
      hs          = axi_arvalid & axi_arready;
      cur_burst   = CW'(axi_arlen) + CW'(1);
      rem_after   = beats_rem - cur_burst;
      len_round   = {1'b0, cfg_length} + (CW+1)'(WIDTH_RATIO - 1);
      out_inc     = hs ? (outstanding + cur_burst) : outstanding;
      // A return beat with nothing outstanding is ignored rather than wrapping.
      if (axi_rbeat && (out_inc != '0)) outstanding_n = out_inc - CW'(1);
      else outstanding_n = out_inc;
      nb = burst_cap(beats_rem);
`ifdef AXIS_READ_CTRL_4K_EN
      nb = clamp_4k(nb, addr[11:0]);
`endif
      case (state)
         IDLE: begin
            if (cfg_valid && (cfg_length != '0)) begin
               addr_n      = cfg_address;
               data_len_n  = cfg_length;
               beats_rem_n = CW'(len_round >> RATIO_SHIFT);
               state_n     = CONFIG;
            end else if (cfg_valid) begin
               done_n = 1'b1;
            end else begin
               done_n = 1'b0;
            end
         end
         CONFIG: begin
            if (data_cfg_ready) state_n = ADDR;
            else state_n = CONFIG;
         end
         ADDR: begin
            if (hs) begin
               addr_n      = addr + (ADDR_WIDTH'(cur_burst) << BYTE_SHIFT);
               beats_rem_n = rem_after;
               nb          = burst_cap(rem_after);
`ifdef AXIS_READ_CTRL_4K_EN
               nb          = clamp_4k(nb, addr_n[11:0]);
`endif
               if (rem_after == '0) begin
                  done_n    = 1'b1;
                  arvalid_n = 1'b0;
                  state_n   = IDLE;
               end else begin
                  // Present the next burst immediately when credit allows.
                  arvalid_n = fits(outstanding_n, nb);
                  araddr_n  = addr_n;
                  arlen_n   = 8'(nb - CW'(1));
               end
            end else if (!axi_arvalid) begin
               arvalid_n = fits(outstanding_n, nb);
               araddr_n  = addr;
               arlen_n   = 8'(nb - CW'(1));
            end else begin
               arvalid_n = 1'b1;
            end
         end
         default: begin
            state_n   = IDLE;
            arvalid_n = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr            <= '0;
         beats_rem       <= '0;
         outstanding     <= '0;
         data_cfg_length <= '0;
         axi_araddr      <= '0;
         axi_arlen       <= 8'd0;
         axi_arvalid     <= 1'b0;
         done            <= 1'b0;
      end else begin
         addr            <= addr_n;
         beats_rem       <= beats_rem_n;
         outstanding     <= outstanding_n;
         data_cfg_length <= data_len_n;
         axi_araddr      <= araddr_n;
         axi_arlen       <= arlen_n;
         axi_arvalid     <= arvalid_n;
         done            <= done_n;
      end
   end
endmodule

// File: tb/tb_axis_read_ctrl.sv
`timescale 1ns/1ps
// Bench for axis_read_ctrl: directed and random transfers checked against a burst-list model
// with an outstanding-beat count; AXIS_READ_CTRL_4K_EN selects the 4 KB-split model.
module tb_axis_read_ctrl;
   localparam int MAXB  = 16;
   localparam int OMAX  = 64;
   localparam int RATIO = 2;
   localparam int BPB   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cfg_address, cfg_length, data_cfg_length, axi_araddr;
   logic        cfg_valid, cfg_ready, data_cfg_valid, data_cfg_ready;
   logic [7:0]  axi_arlen;
   logic        axi_arvalid, axi_arready, axi_rbeat, done;

   int checks   = 0;
   int failures = 0;
   int model_out = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] beats;
   } burst_t;
   burst_t exp_q[$];

   axis_read_ctrl dut (
      .clk(clk), .rst(rst),
      .cfg_address(cfg_address), .cfg_length(cfg_length),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .data_cfg_length(data_cfg_length), .data_cfg_valid(data_cfg_valid),
      .data_cfg_ready(data_cfg_ready),
      .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rbeat(axi_rbeat), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected burst list for one transfer.
   function automatic void plan(input logic [31:0] a, input int len);
      int beats, b;
`ifdef AXIS_READ_CTRL_4K_EN
      int to4k;
`endif
      beats = (len + RATIO - 1) / RATIO;
      while (beats > 0) begin
         b = (beats < MAXB) ? beats : MAXB;
`ifdef AXIS_READ_CTRL_4K_EN
         to4k = (4096 - int'(a % 32'd4096)) / BPB;
         if (to4k < b) b = to4k;
`endif
         exp_q.push_back('{a, 32'(b)});
         a = a + 32'(b * BPB);
         beats -= b;
      end
   endfunction

   task automatic drain();
      int n = 0;
      while (model_out > 0 && n < 500) begin
         axi_rbeat = 1'b1;
         @(posedge clk); #1;
         model_out--;
         n++;
      end
      axi_rbeat = 1'b0;
   endtask

   // mode 0: random rbeats; 1: hold rbeats until credit blocks, then release 16; 2: no rbeats.
   task automatic run_xfer(input logic [31:0] a, input int len, input int mode);
      int   n, stall, blocked, release_n;
      logic hs, rb, pend, saw_block, released;
      plan(a, len);
      n = 0;
      while (cfg_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("cfg_ready_idle", cfg_ready, 1);
      cfg_address = a; cfg_length = 32'(len); cfg_valid = 1'b1;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      if (len == 0) begin
         chk("zero_done", done, 1);
         chk("zero_no_cfg", data_cfg_valid, 0);
         chk("zero_cfg_ready", cfg_ready, 1);
         chk("zero_no_ar", axi_arvalid, 0);
         @(posedge clk); #1;
         chk("zero_done_pulse", done, 0);
         return;
      end
      chk("data_cfg_valid", data_cfg_valid, 1);
      chk("data_cfg_length", data_cfg_length, len);
      chk("cfg_ready_busy", cfg_ready, 0);
      repeat ($urandom_range(0, 3)) begin
         @(posedge clk); #1;
         chk("data_cfg_hold", data_cfg_valid, 1);
         chk("ar_in_config", axi_arvalid, 0);
      end
      data_cfg_ready = 1'b1;
      @(posedge clk); #1;
      data_cfg_ready = 1'b0;
      chk("data_cfg_drop", data_cfg_valid, 0);
      stall = 0; blocked = 0; release_n = 0; pend = 0; saw_block = 0; released = 0;
      for (int cyc = 0; cyc < 3000 && exp_q.size() > 0; cyc++) begin
         if (pend) chk("arvalid_hold", axi_arvalid, 1);
         chk("done_quiet", done, 0);
         if (axi_arvalid) begin
            chk("araddr", axi_araddr, exp_q[0].addr);
            chk("arlen", axi_arlen, exp_q[0].beats - 1);
            chk("credit", (model_out + int'(exp_q[0].beats) <= OMAX), 1);
            stall = 0; blocked = 0;
         end else if (model_out + int'(exp_q[0].beats) <= OMAX) begin
            stall++; blocked = 0;
            chk("ar_liveness", stall <= 2, 1);
         end else begin
            stall = 0; blocked++; saw_block = 1'b1;
         end
         axi_arready = ($urandom_range(0, 3) != 0);
         if (mode == 0) begin
            rb = (model_out > 0) && ($urandom_range(0, 1) == 1);
         end else if (mode == 1) begin
            if (blocked >= 8 && !released) begin released = 1'b1; release_n = 16; end
            rb = (release_n > 0);
            if (rb) release_n--;
         end else begin
            rb = 1'b0;
         end
         axi_rbeat = rb;
         hs   = axi_arvalid && axi_arready;
         pend = axi_arvalid && !axi_arready;
         @(posedge clk); #1;
         if (hs) begin
            model_out += int'(exp_q[0].beats);
            exp_q.delete(0);
         end
         if (rb) model_out--;
         if (hs && exp_q.size() == 0) begin
            chk("done_pulse", done, 1);
            chk("cfg_ready_back", cfg_ready, 1);
         end
      end
      axi_arready = 1'b0;
      axi_rbeat   = 1'b0;
      chk("all_bursts_issued", exp_q.size(), 0);
      if (mode == 1) chk("credit_block_seen", saw_block, 1);
      exp_q.delete();
   endtask

   initial begin
      int          n, rl;
      logic [31:0] ra;
      rst = 1'b1; cfg_valid = 1'b0; cfg_address = '0; cfg_length = '0;
      data_cfg_ready = 1'b0; axi_arready = 1'b0; axi_rbeat = 1'b0;
      #12;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_data_cfg_valid", data_cfg_valid, 0);
      chk("rst_arvalid", axi_arvalid, 0);
      chk("rst_done", done, 0);
      chk("rst_araddr", axi_araddr, 0);
      chk("rst_arlen", axi_arlen, 0);
      chk("rst_data_cfg_length", data_cfg_length, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_cfg_ready", cfg_ready, 1);

      run_xfer(32'h0000_1000, 64, 0);  drain();
      run_xfer(32'h0000_2000, 5, 0);   drain();
      run_xfer(32'h0000_2100, 0, 0);
      run_xfer(32'h0000_4000, 160, 1); drain();
      run_xfer(32'h0000_0FC0, 64, 0);  drain();

      // Reset while the second burst of a transfer is presented.
      cfg_address = 32'h0000_5000; cfg_length = 32'd64; cfg_valid = 1'b1;
      @(posedge clk); #1;
      cfg_valid = 1'b0; data_cfg_ready = 1'b1;
      @(posedge clk); #1;
      data_cfg_ready = 1'b0;
      n = 0;
      while (!axi_arvalid && n < 10) begin @(posedge clk); #1; n++; end
      chk("rst_pre_first_ar", axi_arvalid, 1);
      axi_arready = 1'b1;
      @(posedge clk); #1;
      axi_arready = 1'b0;
      chk("rst_pre_second_ar", axi_arvalid, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_arvalid", axi_arvalid, 0);
      chk("async_rst_data_cfg_valid", data_cfg_valid, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_cfg_ready", cfg_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      model_out = 0;
      @(posedge clk); #1;
      chk("rst_release_cfg_ready", cfg_ready, 1);
      chk("rst_release_arvalid", axi_arvalid, 0);
      // Full credit window with no returns proves outstanding was cleared.
      run_xfer(32'h0000_3000, 128, 2); drain();

      for (int i = 0; i < 24; i++) begin
         ra = $urandom & 32'hFFFF_FFF8;
         if (i % 6 == 5) ra = 32'hFFFF_FF00 | (ra & 32'h0000_00F8);
         rl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 120));
         run_xfer(ra, rl, 0);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
